// File: rtl/rr_arbiter8_pkg.sv
// rr_arbiter8_pkg: shared types, sizes and the round-robin search used by rr_arbiter8.
package rr_arbiter8_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {IDLE, GRANT} state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Scans from last+1 upward with natural 3-bit wrap; the holder itself comes last and can be excluded.
    function automatic pick_t rr_pick(
        input logic [N_REQ-1:0] req,
        input logic [IDX_W-1:0] last,
        input logic             excl,
        input logic [IDX_W-1:0] holder
    );
        pick_t            p;
        logic [IDX_W-1:0] k;
        p = '0;
        for (int i = 0; i < N_REQ; i++) begin
            k = last + IDX_W'(i + 1);
            if (!p.found && req[k] && !(excl && k == holder)) begin
                p.found = 1'b1;
                p.idx   = k;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/onehot_dec3x8.sv
// onehot_dec3x8: 3-to-8 one-hot decoder, all-zero when not enabled.
module onehot_dec3x8
    import rr_arbiter8_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [N_REQ-1:0] onehot
);

    assign onehot = en ? (N_REQ'(1) << idx) : '0;

endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with registered grant and a hold limit
// that forces rotation when other requesters are waiting.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    localparam int HW = $clog2(MAX_HOLD);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, last_q, last_d;
    logic [HW-1:0]    hold_q, hold_d;
    pick_t            pick;
    logic             held, at_limit, moving;

    always_comb begin
        held     = req[idx_q];
        at_limit = hold_q == HW'(MAX_HOLD - 1);
        pick     = rr_pick(req, last_q, state_q == GRANT, idx_q);
        moving   = state_q == IDLE || !held || at_limit;
        state_d  = state_q;
        idx_d    = idx_q;
        last_d   = last_q;
        hold_d   = hold_q;
        if (moving && pick.found) begin
            state_d = GRANT;
            idx_d   = pick.idx;
            last_d  = pick.idx;
            hold_d  = '0;
        end else if (state_q == GRANT && !held) begin
            state_d = IDLE;
            idx_d   = '0;
            hold_d  = '0;
        end else if (state_q == GRANT && !at_limit) begin
            hold_d  = hold_q + HW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt_idx   = idx_q;
    assign gnt_valid = state_q == GRANT;

    onehot_dec3x8 u_dec (
        .idx    (idx_q),
        .en     (gnt_valid),
        .onehot (gnt)
    );

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameter MAX_HOLD, default 16, meaning max consecutive grant cycles before forced rotation when others wait; legal range 2..256.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  8  request per requester; bit k high = requester k wants the shared resource.
REQ-005 gnt  output  8  one-hot grant; all-zero when idle.
REQ-006 gnt_idx  output  3  binary index of current holder; 0 when idle.
REQ-007 gnt_valid  output  1  high while any grant is active.

Function
REQ-008 Two states SHALL exist: IDLE (no holder) and GRANT (one holder).
REQ-009 Outputs SHALL be registered; a request first sampled at edge n SHALL produce its grant visible after edge n, i.e. one-cycle latency.
REQ-010 The search order SHALL be round-robin, starting at (last_idx+1) mod 8 and wrapping 7->0; last_idx SHALL update to the new holder on every grant.
REQ-011 IDLE->GRANT: at an edge with req != 0, grant the first set bit in search order.
REQ-012 In GRANT, holder keeps the grant while req[gnt_idx] stays high and the hold limit is not reached.
REQ-013 Release: at an edge where req[gnt_idx]=0, the arbiter SHALL grant the next requester in search order, skipping the holder, on that same edge; if none, go to IDLE with gnt=0.
REQ-014 hold_cnt SHALL clear to 0 on each new grant and increment each GRANT cycle, saturating at MAX_HOLD-1.
REQ-015 Preemption: at an edge with hold_cnt==MAX_HOLD-1 and any other req bit set, the grant SHALL move to the next requester in search order even if the holder still requests.
REQ-016 If the holder is the only requester at the limit, the grant SHALL be kept and hold_cnt SHALL stay saturated.
REQ-017 gnt SHALL always equal the one-hot decode of gnt_idx when gnt_valid=1, and 8'h00 otherwise; at most one gnt bit SHALL ever be high.
REQ-018 Requests arriving or dropping in the same cycle as a handover SHALL be evaluated only against the req value sampled at that edge.
REQ-019 No requester SHALL wait more than 7*MAX_HOLD cycles while continuously requesting.

Reset
REQ-020 On rst_n low, asynchronously: state=IDLE, gnt=8'h00, gnt_idx=0, gnt_valid=0, hold_cnt=0, last_idx=7 (first search starts at requester 0).
REQ-021 Reset asserted mid-grant SHALL drop gnt immediately, without waiting for a clock edge; after release, arbitration resumes on the first edge with req != 0.

Structure
REQ-022 A shared package SHALL hold the state enum (IDLE, GRANT), the constant N_REQ=8 and the index width 3.
REQ-023 The one-hot gnt output SHALL come from one combinational sub-module, onehot_dec3x8 (3-bit in, 8-bit one-hot out, gated by gnt_valid), instantiated once.
REQ-024 The round-robin search SHALL be a pure combinational function of req, last_idx and the exclude-holder flag, with no extra latency.

Verification
REQ-025 Reset then req=8'h01 -> after 1 edge gnt=8'h01, gnt_idx=0, gnt_valid=1.
REQ-026 Holder 0 granted, req=8'h0F, holder drops bit0 -> same edge gnt=8'h02; then bit1 drops -> gnt=8'h04; then bit2 drops -> gnt=8'h08.
REQ-027 MAX_HOLD=4, req=8'h81 held constant from reset -> gnt alternates 8'h01 (4 cycles), 8'h80 (4 cycles), 8'h01, and so on.
REQ-028 MAX_HOLD=4, req=8'h20 only -> gnt=8'h20 held 20+ cycles, hold_cnt saturated at 3, no drop.
REQ-029 Holder 7 granted, req=8'h81 (bit7 drops) -> wrap: gnt=8'h01 on that edge; req=8'h00 next -> IDLE, gnt=8'h00.
REQ-030 rst_n pulsed low mid-grant with gnt=8'h10 -> gnt=8'h00 asynchronously; after release with req=8'h18 -> first grant gnt=8'h08 (search restarts at 0).
